// File: rtl/gg_nal_dispatch_lattice.sv
// gg_nal_dispatch_lattice: start-code scan, NAL/slice header decode and slice dispatch
module gg_nal_dispatch_lattice #(
  parameter int WIDTH = 32,
  parameter int BYTE_WIDTH = WIDTH / 8,
  parameter int NUM_CH = 2,
  parameter logic [3*NUM_CH-1:0] CH_TYPE_MASK = 6'b100_011,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             in_bits,
  input  logic [31:0]                  in_pad,
  input  logic [BYTE_WIDTH-1:0]        nal_start,
  output logic [BYTE_WIDTH-1:0]        nal_end,
  output logic [NUM_CH*BYTE_WIDTH-1:0] slice_start,
  input  logic [NUM_CH*BYTE_WIDTH-1:0] slice_end,
  output logic                         busy,
  output logic                         err,
  output logic [CNT_W-1:0]             nal_cnt,
  output logic [CNT_W-1:0]             slice_cnt,
  output logic [CNT_W-1:0]             skip_cnt
);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam logic [NUM_CH*BYTE_WIDTH-1:0] lsb_one = 1;
  typedef enum logic [1:0] {IDLE, SEARCH, HDR, OWNED} state_t;
  state_t state, st;
  logic [1:0] run, r;
  logic ss_pend, sp, e, sl, ch_ok;
  logic [CW-1:0] owner, ow, ch;
  logic [7:0] ni, si, ki, hb;
  logic [2:0] k, acc;
  logic [BYTE_WIDTH-1:0] ne;
  logic [NUM_CH*BYTE_WIDTH-1:0] ss;
  logic [WIDTH+31:0] cat;
  // {ok, type}: type 0=P 1=B 2=I from first_mb_in_slice + slice_type exp-Golomb codes
  function automatic logic [2:0] kind(input logic [31:0] b);
    logic [4:0] lz1, v, m;
    logic [2:0] lz2;
    logic [31:0] s, suf;
    lz1 = 5'd13;
    for (int j = 12; j >= 0; j--) if (b[31-j]) lz1 = 5'(j);
    s = b << {lz1, 1'b1};
    lz2 = 3'd4;
    for (int j = 3; j >= 0; j--) if (s[31-j]) lz2 = 3'(j);
    suf = (s >> (6'd31 - {2'b00, lz2, 1'b0})) & ((32'd1 << lz2) - 32'd1);
    v = 5'((32'd1 << lz2) - 32'd1 + suf);
    m = v % 5'd5;
    return (lz1 != 5'd13 && lz2 != 3'd4 && v <= 5'd9 && m < 5'd3) ? {1'b1, m[1:0]} : 3'd0;
  endfunction
  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] a, input logic [7:0] d);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-7){1'b0}}, d};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction
  assign cat = {in_bits, in_pad};
  always_comb begin
    st = state;
    r = run;
    sp = ss_pend;
    ow = owner;
    ne = '0;
    ss = '0;
    e = 1'b0;
    ni = '0;
    si = '0;
    ki = '0;
    hb = '0;
    k = '0;
    acc = '0;
    ch = '0;
    ch_ok = 1'b0;
    sl = 1'b0;
    for (int i = BYTE_WIDTH-1; i >= 0; i--) begin
      hb = in_bits[i*8 +: 8];
      if (sp) begin
        ss = ss | (lsb_one << (int'(ow) * BYTE_WIDTH + i));
        sp = 1'b0;
      end
      for (int c = 0; c < NUM_CH; c++)
        if (slice_end[c*BYTE_WIDTH+i]) begin
          if (st == OWNED && ow == CW'(c)) begin
            ne[i] = 1'b1;
            st = SEARCH;
            r = 2'd0;
          end else e = 1'b1;
        end
      if (nal_start[i]) begin
        if (st == OWNED) e = 1'b1;
        else begin
          st = SEARCH;
          r = 2'd0;
        end
      end
      if (st == SEARCH) begin
        if (hb == 8'h01 && r == 2'd2) begin
          st = HDR;
          r = 2'd0;
          ni = ni + 8'd1;
        end else r = hb != 8'h00 ? 2'd0 : r == 2'd2 ? 2'd2 : r + 2'd1;
      end else if (st == HDR) begin
        k = kind(cat[i*8 +: 32]);
        ch_ok = 1'b0;
        ch = '0;
        // descending scan leaves the lowest accepting channel selected
        for (int c = NUM_CH-1; c >= 0; c--) begin
          acc = CH_TYPE_MASK[3*c +: 3];
          if (acc[k[1:0]]) begin
            ch_ok = 1'b1;
            ch = CW'(c);
          end
        end
        sl = hb[4:0] == 5'd1 || hb[4:0] == 5'd5;
        if (!hb[7] && sl && k[2] && ch_ok) begin
          st = OWNED;
          ow = ch;
          sp = 1'b1;
          si = si + 8'd1;
        end else begin
          st = SEARCH;
          r = 2'd0;
          ki = ki + 8'd1;
          e = e | hb[7] | (sl & ~k[2]);
        end
      end
    end
  end
  assign nal_end = reset ? '0 : ne;
  assign slice_start = reset ? '0 : ss;
  assign err = !reset && e;
  assign busy = state == OWNED;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      run <= '0;
      ss_pend <= 1'b0;
      owner <= '0;
      nal_cnt <= '0;
      slice_cnt <= '0;
      skip_cnt <= '0;
    end else begin
      state <= st;
      run <= r;
      ss_pend <= sp;
      owner <= ow;
      nal_cnt <= sat(nal_cnt, ni);
      slice_cnt <= sat(slice_cnt, si);
      skip_cnt <= sat(skip_cnt, ki);
    end
endmodule

// File: tb/tb_gg_nal_dispatch_lattice.sv
// tb_gg_nal_dispatch_lattice: scoreboard bench, W=32 default mask and W=64 P/I-only mask
module tb_gg_nal_dispatch_lattice;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [31:0] a_bits, a_pad, b_pad;
  logic [63:0] b_bits;
  logic [3:0] a_ns, a_ne;
  logic [7:0] a_se, a_ss, b_ns, b_ne;
  logic [15:0] b_se, b_ss, a_nal, a_sl, a_sk, b_nal, b_sl, b_sk;
  logic a_busy, a_err, b_busy, b_err;
  logic va = 1'b0, vb = 1'b0;
  int ncmp = 0, nbad = 0;
  typedef struct {
    int id;
    logic [15:0] ss;
    logic [7:0] ne;
    logic err, busy;
    logic [15:0] nal, sl, sk;
  } exp_t;
  exp_t qa[$], qb[$];
  gg_nal_dispatch_lattice dut_a (
    .clk(clk), .reset(reset), .in_bits(a_bits), .in_pad(a_pad), .nal_start(a_ns),
    .nal_end(a_ne), .slice_start(a_ss), .slice_end(a_se), .busy(a_busy), .err(a_err),
    .nal_cnt(a_nal), .slice_cnt(a_sl), .skip_cnt(a_sk));
  gg_nal_dispatch_lattice #(.WIDTH(64), .CH_TYPE_MASK(6'b100_001)) dut_b (
    .clk(clk), .reset(reset), .in_bits(b_bits), .in_pad(b_pad), .nal_start(b_ns),
    .nal_end(b_ne), .slice_start(b_ss), .slice_end(b_se), .busy(b_busy), .err(b_err),
    .nal_cnt(b_nal), .slice_cnt(b_sl), .skip_cnt(b_sk));
  function automatic exp_t mk(int id, logic [15:0] ss, logic [7:0] ne, logic err, logic busy,
                              logic [15:0] nal, logic [15:0] sl, logic [15:0] sk);
    mk.id = id;
    mk.ss = ss;
    mk.ne = ne;
    mk.err = err;
    mk.busy = busy;
    mk.nal = nal;
    mk.sl = sl;
    mk.sk = sk;
  endfunction
  task automatic cmp(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s vec %0d: got %0h, expected %0h", name, id, act, exp);
    end
  endtask
  task automatic drive_a(input logic [31:0] b, input logic [31:0] p, input logic [3:0] ns,
                         input logic [7:0] se, input exp_t e);
    @(negedge clk);
    a_bits = b;
    a_pad = p;
    a_ns = ns;
    a_se = se;
    va = 1'b1;
    qa.push_back(e);
  endtask
  task automatic drive_b(input logic [63:0] b, input logic [7:0] ns, input logic [15:0] se,
                         input bit chk, input exp_t e);
    @(negedge clk);
    b_bits = b;
    b_pad = '0;
    b_ns = ns;
    b_se = se;
    vb = chk;
    if (chk) qb.push_back(e);
  endtask
  // monitors: combinational outputs before the edge, registered ones just after it
  initial forever begin
    @(negedge clk);
    #2;
    if (va) begin
      exp_t e;
      if (qa.size() == 0) begin
        cmp("qa_underflow", 0, 1, 0);
      end else begin
        e = qa.pop_front();
        cmp("a_slice_start", e.id, 64'(a_ss), 64'(e.ss[7:0]));
        cmp("a_nal_end", e.id, 64'(a_ne), 64'(e.ne[3:0]));
        cmp("a_err", e.id, 64'(a_err), 64'(e.err));
        @(posedge clk);
        #1;
        cmp("a_busy", e.id, 64'(a_busy), 64'(e.busy));
        cmp("a_nal_cnt", e.id, 64'(a_nal), 64'(e.nal));
        cmp("a_slice_cnt", e.id, 64'(a_sl), 64'(e.sl));
        cmp("a_skip_cnt", e.id, 64'(a_sk), 64'(e.sk));
      end
    end
  end
  initial forever begin
    @(negedge clk);
    #2;
    if (vb) begin
      exp_t e;
      if (qb.size() == 0) begin
        cmp("qb_underflow", 0, 1, 0);
      end else begin
        e = qb.pop_front();
        cmp("b_slice_start", e.id, 64'(b_ss), 64'(e.ss));
        cmp("b_nal_end", e.id, 64'(b_ne), 64'(e.ne));
        cmp("b_err", e.id, 64'(b_err), 64'(e.err));
        @(posedge clk);
        #1;
        cmp("b_busy", e.id, 64'(b_busy), 64'(e.busy));
        cmp("b_nal_cnt", e.id, 64'(b_nal), 64'(e.nal));
        cmp("b_slice_cnt", e.id, 64'(b_sl), 64'(e.sl));
        cmp("b_skip_cnt", e.id, 64'(b_sk), 64'(e.sk));
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    a_bits = '0; a_pad = '0; a_ns = '0; a_se = '0;
    b_bits = '0; b_pad = '0; b_ns = '0; b_se = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    //      bits          pad           ns       se     id  ss     ne      err busy nal sl sk
    drive_a(32'h00000165, 32'h88000000, 4'b0000, 8'h00, mk(0, 0, 0, 0, 0, 0, 0, 0));
    drive_a(32'h00000165, 32'h88000000, 4'b1000, 8'h00, mk(1, 0, 0, 0, 1, 1, 1, 0));
    drive_a(32'hAABBCCDD, 32'h0, 4'b0000, 8'h00, mk(2, 16'h80, 0, 0, 1, 1, 1, 0));
    drive_a(32'h00000000, 32'h0, 4'b0000, 8'h02, mk(3, 0, 0, 1, 1, 1, 1, 0));
    drive_a(32'h00000000, 32'h0, 4'b0100, 8'h00, mk(4, 0, 0, 1, 1, 1, 1, 0));
    drive_a(32'h00000141, 32'hC0000000, 4'b0000, 8'h80, mk(5, 0, 8'h8, 0, 1, 2, 2, 0));
    drive_a(32'h11223344, 32'h0, 4'b0000, 8'h00, mk(6, 16'h08, 0, 0, 1, 2, 2, 0));
    drive_a(32'hFFFFFFFF, 32'h0, 4'b0000, 8'h04, mk(7, 0, 8'h4, 0, 0, 2, 2, 0));
    drive_a(32'hFF000001, 32'h0, 4'b0000, 8'h00, mk(8, 0, 0, 0, 0, 3, 2, 0));
    drive_a(32'h06000001, 32'h0, 4'b0000, 8'h00, mk(9, 0, 0, 0, 0, 4, 2, 1));
    drive_a(32'h41A00000, 32'h0, 4'b0000, 8'h00, mk(10, 16'h04, 0, 0, 1, 4, 3, 1));
    drive_a(32'h00000000, 32'h0, 4'b0000, 8'h01, mk(11, 0, 8'h1, 0, 0, 4, 3, 1));
    drive_a(32'h00016588, 32'h0, 4'b0000, 8'h00, mk(12, 16'h10, 0, 0, 1, 5, 4, 1));
    drive_a(32'h00000000, 32'h0, 4'b0000, 8'h10, mk(13, 0, 8'h1, 0, 0, 5, 4, 1));
    drive_a(32'h000181FF, 32'h0, 4'b0000, 8'h00, mk(14, 0, 0, 1, 0, 6, 4, 2));
    drive_a(32'h00000141, 32'h90000000, 4'b0000, 8'h00, mk(15, 0, 0, 1, 0, 7, 4, 3));
    drive_a(32'h00000101, 32'h0, 4'b0000, 8'h00, mk(16, 0, 0, 1, 0, 8, 4, 4));
    drive_a(32'hFFFFFFFF, 32'h0, 4'b0000, 8'h01, mk(17, 0, 0, 1, 0, 8, 4, 4));
    drive_a(32'h00000165, 32'h88000000, 4'b0000, 8'h00, mk(18, 0, 0, 0, 1, 9, 5, 4));
    @(negedge clk);
    va = 1'b0;
    a_bits = '0; a_pad = '0; a_ns = '0; a_se = '0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive_a(32'h00000000, 32'h0, 4'b0000, 8'h00, mk(19, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    va = 1'b0;
    a_bits = '0;
    drive_b(64'h0000010600000107, 8'h80, 16'h0000, 1, mk(100, 0, 0, 0, 0, 2, 0, 2));
    drive_b(64'h00000141A00000FF, 8'h00, 16'h0000, 1, mk(101, 0, 0, 0, 0, 3, 0, 3));
    drive_b(64'h00000141C0FFFFFF, 8'h00, 16'h0000, 1, mk(102, 16'h0008, 0, 0, 1, 4, 1, 3));
    drive_b(64'hFFFFFFFFFFFFFFFF, 8'h00, 16'h2000, 1, mk(103, 0, 0, 1, 1, 4, 1, 3));
    drive_b(64'hFFFFFFFFFFFFFFFF, 8'h00, 16'h0040, 1, mk(104, 0, 8'h40, 0, 0, 4, 1, 3));
    for (int n = 0; n < 32764; n++)
      drive_b(64'h0000010600000106, 8'h00, 16'h0000, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    drive_b(64'h0000010600000106, 8'h00, 16'h0000, 1, mk(105, 0, 0, 0, 0, 16'hFFFE, 1, 16'hFFFD));
    drive_b(64'h0000010600000106, 8'h00, 16'h0000, 1, mk(106, 0, 0, 0, 0, 16'hFFFF, 1, 16'hFFFF));
    drive_b(64'h0000010600000106, 8'h00, 16'h0000, 1, mk(107, 0, 0, 0, 0, 16'hFFFF, 1, 16'hFFFF));
    @(negedge clk);
    vb = 1'b0;
    b_bits = '0;
    repeat (3) @(posedge clk);
    cmp("qa_drained", 0, 64'(qa.size()), 0);
    cmp("qb_drained", 0, 64'(qb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
